// File: rtl/ff_inv.sv
// GF(P) inverter: a^(P-2) mod P by left-to-right square-and-multiply over an external multiplier.
// Optional zero-input short-circuit enabled by defining FF_INV_ZERO_FLAG_EN.
module ff_inv #(
  parameter int             W = 255,
  parameter logic [W-1:0]   P = {W{1'b1}} - W'(18)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         zero_err,
  output logic         mul_start,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_result,
  input  logic         mul_valid
);

`ifdef FF_INV_ZERO_FLAG_EN
  localparam bit ZERO_FLAG_EN = 1'b1;
`else
  localparam bit ZERO_FLAG_EN = 1'b0;
`endif

  localparam logic [W-1:0] E = P - W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_SQR_W,
    S_MUL,
    S_MUL_W,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] base_q, base_d;
  logic [W-1:0] acc_q, acc_d;
  logic [7:0]   idx_q, idx_d;
  logic [W-1:0] result_q, result_d;
  logic         zero_err_q, zero_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      zero_err_q <= zero_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    result_d   = result_q;
    zero_err_d = zero_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The exponent MSB is always 1, so the first step is just acc = a.
          base_d     = a;
          acc_d      = a;
          idx_d      = 8'(W - 2);
          zero_err_d = 1'b0;
          state_d    = S_SQR;
          if (ZERO_FLAG_EN && ((a == '0) || (a == P))) begin
            acc_d      = '0;
            zero_err_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_SQR: state_d = S_SQR_W;
      S_SQR_W: begin
        if (mul_valid) begin
          acc_d = mul_result;
          if (E[idx_q]) begin
            state_d = S_MUL;
          end else if (idx_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_SQR;
          end
        end
      end
      S_MUL: state_d = S_MUL_W;
      S_MUL_W: begin
        if (mul_valid) begin
          acc_d = mul_result;
          if (idx_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 8'd1;
            state_d = S_SQR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture on entry to DONE so result is already valid while done is high.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      result_d = acc_d;
    end
  end

  always_comb begin
    mul_start = (state_q == S_SQR) || (state_q == S_MUL);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
    zero_err  = zero_err_q;
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      S_SQR, S_SQR_W: begin
        mul_a = acc_q;
        mul_b = acc_q;
      end
      S_MUL, S_MUL_W: begin
        mul_a = acc_q;
        mul_b = base_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

endmodule
